// File: rtl/lb_line_drain.sv
// lb_line_drain: reader end of the MSHR line buffer.
// On request, walks the LB_BEATS rows of one line slot through the
// line-buffer combinational read port and presents them as a registered
// ready/valid beat stream. Only one output beat register is held.
// Optional feature macro: LB_LINE_DRAIN_PARITY_EN adds out_parity,
// exp_parity and a sticky par_err flag.
module lb_line_drain #(
    parameter int  LB_LINES = 4,
    parameter int  LB_BEATS = 8,
    parameter int  DATA_W   = 64,
    parameter int  ADDR_W   = 5,
    localparam int ID_W     = $clog2(LB_LINES),
    localparam int BEAT_W   = $clog2(LB_BEATS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_lb_id,
    input  logic              kill,
    output logic              lb_r_en,
    output logic [ADDR_W-1:0] lb_r_addr,
    input  logic [DATA_W-1:0] lb_r_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [BEAT_W-1:0] out_beat,
    output logic              out_last,
    output logic              done
`ifdef LB_LINE_DRAIN_PARITY_EN
    ,
    input  logic              exp_parity,
    output logic              out_parity,
    output logic              par_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t              state_reg;
    logic [ID_W-1:0]     lb_id_reg;
    logic [BEAT_W-1:0]   rd_beat_reg;
    logic [ADDR_W-1:0]   addr_hold_reg;
    logic                out_valid_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic [BEAT_W-1:0]   out_beat_reg;
    logic                out_last_reg;
    logic                done_reg;
    logic                load;
    logic                last_rd;
    logic [ADDR_W-1:0]   rd_addr;

    // A row is fetched whenever the output register is empty or being emptied.
    assign load    = (state_reg == READ) && (!out_valid_reg || out_ready);
    assign last_rd = (rd_beat_reg == BEAT_W'(LB_BEATS - 1));
    assign rd_addr = {lb_id_reg, rd_beat_reg};

    // The address bus only moves on a read so the line buffer sees a quiet port otherwise.
    assign lb_r_en   = load;
    assign lb_r_addr = load ? rd_addr : addr_hold_reg;

    assign req_ready = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_beat  = out_beat_reg;
    assign out_last  = out_last_reg;
    assign done      = done_reg;

    // Drain FSM: request latch, beat loading, final-beat hand-off and kill abort.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            lb_id_reg     <= '0;
            rd_beat_reg   <= '0;
            addr_hold_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_beat_reg  <= '0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                addr_hold_reg <= rd_addr;
            end
            case (state_reg)
                IDLE: begin
                    // kill is meaningless here, so a same-cycle request still starts.
                    if (req_valid) begin
                        lb_id_reg   <= req_lb_id;
                        rd_beat_reg <= '0;
                        state_reg   <= READ;
                    end
                end
                READ: begin
                    if (kill) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (load) begin
                        out_data_reg  <= lb_r_data;
                        out_beat_reg  <= rd_beat_reg;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= last_rd;
                        rd_beat_reg   <= rd_beat_reg + 1'b1;
                        if (last_rd) begin
                            state_reg <= LAST;
                        end
                    end
                end
                LAST: begin
                    // kill beats a same-cycle accept: the final beat is treated as undelivered.
                    if (kill) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef LB_LINE_DRAIN_PARITY_EN
    logic par_err_reg;

    assign out_parity = ^out_data_reg;
    assign par_err    = par_err_reg;

    // Sticky flag: any row whose data parity disagrees with the stored parity bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            par_err_reg <= 1'b0;
        end else if (load && ((^lb_r_data) != exp_parity)) begin
            par_err_reg <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lb_line_drain.sv
// Self-checking bench for lb_line_drain. The bench owns the line buffer
// (a 32 x 64b array read combinationally) and predicts every beat from it.
module tb_lb_line_drain;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_lb_id;
    logic        kill;
    logic        lb_r_en;
    logic [4:0]  lb_r_addr;
    logic [63:0] lb_r_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [2:0]  out_beat;
    logic        out_last;
    logic        done;
`ifdef LB_LINE_DRAIN_PARITY_EN
    logic        exp_parity;
    logic        out_parity;
    logic        par_err;
`endif

    logic [63:0] mem [32];
    int          inject_addr = -1;
    logic        par_exp = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clock = ~clock;

    assign lb_r_data = mem[lb_r_addr];
`ifdef LB_LINE_DRAIN_PARITY_EN
    assign exp_parity = (^lb_r_data) ^ (lb_r_en && (int'(lb_r_addr) == inject_addr));
`endif

    lb_line_drain dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_lb_id (req_lb_id),
        .kill      (kill),
        .lb_r_en   (lb_r_en),
        .lb_r_addr (lb_r_addr),
        .lb_r_data (lb_r_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .done      (done)
`ifdef LB_LINE_DRAIN_PARITY_EN
        ,
        .exp_parity(exp_parity),
        .out_parity(out_parity),
        .par_err   (par_err)
`endif
    );

    task automatic test_reset();
        par_exp   = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_lb_id = 2'd2;
        kill      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0)
            begin tests_failed++; $display("FAIL reset_out ready=%b valid=%b last=%b done=%b req 1000", req_ready, out_valid, out_last, done); end
        tests_run++;
        if (lb_r_en !== 1'b0 || lb_r_addr !== 5'd0)
            begin tests_failed++; $display("FAIL reset_rd en=%b addr=%0d req en=0 addr=0", lb_r_en, lb_r_addr); end
`ifdef LB_LINE_DRAIN_PARITY_EN
        tests_run++;
        if (par_err !== 1'b0) begin tests_failed++; $display("FAIL reset_par par_err=%b req 0", par_err); end
`endif
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || lb_r_en !== 1'b0)
            begin tests_failed++; $display("FAIL reset_idle ready=%b en=%b req 1 0", req_ready, lb_r_en); end
        $display("[TB] reset checked");
    endtask

    // Fixed-timing drain of line 2 with out_ready held high; n counts cycles after acceptance.
    task automatic test_basic();
        req_valid = 1'b1;
        req_lb_id = 2'd2;
        out_ready = 1'b1;
        kill      = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            req_valid = 1'b0;
            #1;
            tests_run++;
            if (lb_r_en !== (n <= 8) || int'(lb_r_addr) !== ((n <= 8) ? 15 + n : 23))
                begin tests_failed++; $display("FAIL basic_rd n=%0d en=%b addr=%0d req en=%b addr=%0d", n, lb_r_en, lb_r_addr, (n <= 8), (n <= 8) ? 15 + n : 23); end
            tests_run++;
            if (out_valid !== (n >= 2 && n <= 9))
                begin tests_failed++; $display("FAIL basic_valid n=%0d valid=%b req %b", n, out_valid, (n >= 2 && n <= 9)); end
            if (n >= 2 && n <= 9) begin
                tests_run++;
                if (out_beat !== 3'(n - 2) || out_data !== mem[14 + n] || out_last !== (n == 9))
                    begin tests_failed++; $display("FAIL basic_beat n=%0d beat=%0d data=%h last=%b req beat=%0d data=%h last=%b", n, out_beat, out_data, out_last, n - 2, mem[14 + n], (n == 9)); end
            end
            tests_run++;
            if (done !== (n == 10) || req_ready !== (n == 10))
                begin tests_failed++; $display("FAIL basic_done n=%0d done=%b ready=%b req %b", n, done, req_ready, (n == 10)); end
        end
        $display("[TB] basic drain line 2 done");
    endtask

    // Drains one line and checks it against the array contents. Starts a request in the
    // current cycle and returns in the cycle done is seen.
    task automatic test_stream(input int line, input int stall_lo, input int stall_hi,
                               input bit rnd, input bit kill_req, input bit hold_next,
                               input int next_line);
        int          rd;
        int          got;
        int          s;
        bit          stalled;
        bit          exp_done;
        bit          finished;
        bit          exp_en;
        logic [63:0] h_data;
        logic [2:0]  h_beat;
        logic        h_last;
        rd = 0; got = 0; s = -1; stalled = 0; exp_done = 0; finished = 0;
        h_data = '0; h_beat = '0; h_last = 1'b0;
        req_valid = 1'b1;
        req_lb_id = line[1:0];
        kill      = kill_req;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_start line=%0d ready=%b req 1", line, req_ready); end
        for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
            @(negedge clock);
            req_valid = hold_next;
            req_lb_id = next_line[1:0];
            kill      = 1'b0;
            if (out_valid) s++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : !(s >= stall_lo && s <= stall_hi);
            #1;
            tests_run++;
            if (done !== exp_done) begin tests_failed++; $display("FAIL stream_done line=%0d cyc=%0d done=%b req %b", line, cyc, done, exp_done); end
            if (exp_done) begin
                finished = 1;
                tests_run++;
                if (req_ready !== 1'b1 || out_valid !== 1'b0 || lb_r_en !== 1'b0)
                    begin tests_failed++; $display("FAIL stream_idle line=%0d ready=%b valid=%b en=%b req 1 0 0", line, req_ready, out_valid, lb_r_en); end
                tests_run++;
                if (got != 8 || rd != 8) begin tests_failed++; $display("FAIL stream_count line=%0d beats=%0d reads=%0d req 8 8", line, got, rd); end
            end else begin
                tests_run++;
                if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL stream_busy line=%0d cyc=%0d ready=%b req 0", line, cyc, req_ready); end
                if (stalled) begin
                    tests_run++;
                    if (out_valid !== 1'b1 || out_data !== h_data || out_beat !== h_beat || out_last !== h_last)
                        begin tests_failed++; $display("FAIL stream_stable line=%0d valid=%b beat=%0d data=%h req beat=%0d data=%h", line, out_valid, out_beat, out_data, h_beat, h_data); end
                end
                exp_en = (rd < 8) && (!out_valid || out_ready);
                tests_run++;
                if (lb_r_en !== exp_en) begin tests_failed++; $display("FAIL stream_en line=%0d cyc=%0d en=%b req %b", line, cyc, lb_r_en, exp_en); end
                if (lb_r_en) begin
                    tests_run++;
                    if (int'(lb_r_addr) != line * 8 + rd)
                        begin tests_failed++; $display("FAIL stream_addr line=%0d addr=%0d req %0d", line, lb_r_addr, line * 8 + rd); end
                    rd++;
                end
`ifdef LB_LINE_DRAIN_PARITY_EN
                if (out_valid) begin
                    tests_run++;
                    if (out_parity !== ^out_data) begin tests_failed++; $display("FAIL stream_parity beat=%0d parity=%b req %b", out_beat, out_parity, ^out_data); end
                end
                tests_run++;
                if (par_err !== par_exp) begin tests_failed++; $display("FAIL stream_par_err cyc=%0d par_err=%b req %b", cyc, par_err, par_exp); end
                if (lb_r_en && int'(lb_r_addr) == inject_addr) par_exp = 1'b1;
`endif
                if (out_valid && out_ready) begin
                    tests_run++;
                    if (got >= 8 || out_beat !== got[2:0] || out_data !== mem[(line * 8 + got) % 32] || out_last !== (got == 7))
                        begin tests_failed++; $display("FAIL stream_beat line=%0d beat=%0d data=%h last=%b req beat=%0d data=%h", line, out_beat, out_data, out_last, got, mem[(line * 8 + got) % 32]); end
                    if (got == 7) exp_done = 1;
                    got++;
                end
                stalled = out_valid && !out_ready;
                h_data  = out_data;
                h_beat  = out_beat;
                h_last  = out_last;
            end
        end
        if (!finished) begin
            tests_run++;
            tests_failed++;
            $display("FAIL stream_timeout line=%0d beats=%0d reads=%0d req 8 8", line, got, rd);
        end
        $display("[TB] drained line %0d: %0d beats, %0d reads", line, got, rd);
    endtask

    task automatic test_backpressure();
        test_stream(1, 3, 5, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        test_stream(3, 99, -1, 1'b0, 1'b0, 1'b1, 0);
        test_stream(0, 99, -1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_kill_idle();
        test_stream(2, 2, 2, 1'b0, 1'b1, 1'b0, 0);
    endtask

    // k=0 kills beat 4 mid-stream, k=1 kills the final beat in the same cycle it is accepted.
    task automatic test_kill();
        for (int k = 0; k < 2; k++) begin
            bit found;
            found     = 0;
            req_valid = 1'b1;
            req_lb_id = 2'(k);
            out_ready = 1'b1;
            kill      = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clock);
                req_valid = 1'b0;
                #1;
                if (out_valid && ((k == 0) ? (out_beat == 3'd4) : (out_last == 1'b1))) found = 1;
            end
            tests_run++;
            if (!found) begin tests_failed++; $display("FAIL kill_reach k=%0d found=0 req 1", k); end
            kill = 1'b1;
            @(negedge clock);
            kill = 1'b0;
            #1;
            tests_run++;
            if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1)
                begin tests_failed++; $display("FAIL kill_next k=%0d valid=%b last=%b done=%b ready=%b req 0 0 0 1", k, out_valid, out_last, done, req_ready); end
            @(negedge clock);
            #1;
            tests_run++;
            if (done !== 1'b0 || out_valid !== 1'b0 || lb_r_en !== 1'b0)
                begin tests_failed++; $display("FAIL kill_after k=%0d done=%b valid=%b en=%b req 0 0 0", k, done, out_valid, lb_r_en); end
            $display("[TB] kill case %0d checked", k);
        end
        test_stream(2, 99, -1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        bit found;
        found     = 0;
        req_valid = 1'b1;
        req_lb_id = 2'd3;
        out_ready = 1'b1;
        kill      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            #1;
            if (out_valid && out_beat == 3'd5) found = 1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL rstmid_reach found=0 req 1"); end
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        par_exp = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1)
            begin tests_failed++; $display("FAIL rstmid_out valid=%b last=%b done=%b ready=%b req 0 0 0 1", out_valid, out_last, done, req_ready); end
        tests_run++;
        if (lb_r_en !== 1'b0 || lb_r_addr !== 5'd0)
            begin tests_failed++; $display("FAIL rstmid_rd en=%b addr=%0d req 0 0", lb_r_en, lb_r_addr); end
        $display("[TB] reset mid-drain checked");
        test_stream(1, 99, -1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_stream(int'($urandom_range(0, 3)), 99, -1, 1'b1, 1'b0, 1'b0, 0);
        end
    endtask

`ifdef LB_LINE_DRAIN_PARITY_EN
    task automatic test_parity();
        inject_addr = 1 * 8 + 3;
        test_stream(1, 99, -1, 1'b0, 1'b0, 1'b0, 0);
        inject_addr = -1;
        tests_run++;
        if (par_err !== 1'b1) begin tests_failed++; $display("FAIL par_set par_err=%b req 1", par_err); end
        test_stream(2, 99, -1, 1'b1, 1'b0, 1'b0, 0);
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        par_exp = 1'b0;
        #1;
        tests_run++;
        if (par_err !== 1'b0) begin tests_failed++; $display("FAIL par_clear par_err=%b req 0", par_err); end
        $display("[TB] parity checked");
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_kill_idle();
        test_kill();
        test_reset_mid();
        test_random();
`ifdef LB_LINE_DRAIN_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
